// File: rtl/vc_fifo_if.sv
// ----------------------------------------------------------------------------
// vc_fifo_if : write/read/status bundle of the multi-VC input buffer
// Rev 1.0    : err_overflow/err_underflow present only with VC_FIFO_ERR_EN
// ----------------------------------------------------------------------------
`default_nettype none

interface vc_fifo_if #(
  parameter int WIDTH  = 64,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 4
);
  localparam int VC_W  = $clog2(NUM_VC);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]        in_data;
  logic [VC_W-1:0]         in_vc;
  logic                    in_valid;
  logic                    in_ready;
  logic [VC_W-1:0]         out_sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_VC-1:0]       vc_nonempty;
  logic [NUM_VC-1:0]       almost_full;
  logic [NUM_VC*CNT_W-1:0] occupancy;
  logic [NUM_VC-1:0]       credit_ret;
`ifdef VC_FIFO_ERR_EN
  logic [NUM_VC-1:0]       err_overflow;
  logic [NUM_VC-1:0]       err_underflow;

  modport master (
    output in_data, in_vc, in_valid, out_sel, out_ready,
    input  in_ready, out_data, out_valid, vc_nonempty, almost_full,
           occupancy, credit_ret, err_overflow, err_underflow
  );
  modport slave (
    input  in_data, in_vc, in_valid, out_sel, out_ready,
    output in_ready, out_data, out_valid, vc_nonempty, almost_full,
           occupancy, credit_ret, err_overflow, err_underflow
  );
`else
  modport master (
    output in_data, in_vc, in_valid, out_sel, out_ready,
    input  in_ready, out_data, out_valid, vc_nonempty, almost_full,
           occupancy, credit_ret
  );
  modport slave (
    input  in_data, in_vc, in_valid, out_sel, out_ready,
    output in_ready, out_data, out_valid, vc_nonempty, almost_full,
           occupancy, credit_ret
  );
`endif
endinterface

`default_nettype wire

// File: rtl/vc_fifo.sv
// ----------------------------------------------------------------------------
// vc_fifo : NUM_VC independent circular FIFOs, shared write port, selected read
// Rev 1.0 : optional sticky error flags under macro VC_FIFO_ERR_EN
// ----------------------------------------------------------------------------
`default_nettype none

module vc_fifo #(
  parameter int WIDTH  = 64,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 4
) (
  input wire        clk,
  input wire        rst_n,
  vc_fifo_if.slave  bus
);
  localparam int VC_W  = $clog2(NUM_VC);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - 1);
  localparam logic [VC_W:0]    VC_LIMIT  = (VC_W + 1)'(NUM_VC);

  logic [WIDTH-1:0]  mem    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [CNT_W-1:0]  count  [NUM_VC];
  logic [NUM_VC-1:0] push_vc;
  logic [NUM_VC-1:0] pop_vc;
  logic [NUM_VC-1:0] credit;
  logic [CNT_W-1:0]  in_count;
  logic [CNT_W-1:0]  out_count;
  logic [WIDTH-1:0]  head_data;
  logic              in_vc_ok;
  logic              in_ready;
  logic              out_valid;

  assign in_vc_ok = ({1'b0, bus.in_vc} < VC_LIMIT);

  // Select by comparison so an out-of-range index matches nothing.
  always_comb begin
    in_count  = '0;
    out_count = '0;
    head_data = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (bus.in_vc == VC_W'(v)) in_count = count[v];
      if (bus.out_sel == VC_W'(v)) begin
        out_count = count[v];
        head_data = mem[v][rd_ptr[v]];
      end
    end
  end

  assign in_ready  = in_vc_ok && (in_count < FULL_CNT);
  assign out_valid = (out_count != '0);

  always_comb begin
    push_vc = '0;
    pop_vc  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_vc[v] = bus.in_valid && in_ready && (bus.in_vc == VC_W'(v));
      pop_vc[v]  = bus.out_ready && out_valid && (bus.out_sel == VC_W'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
      credit <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_vc[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        if (pop_vc[v])  rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        if (push_vc[v] && !pop_vc[v])      count[v] <= count[v] + CNT_W'(1);
        else if (!push_vc[v] && pop_vc[v]) count[v] <= count[v] - CNT_W'(1);
      end
      credit <= pop_vc;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_vc[v]) mem[v][wr_ptr[v]] <= bus.in_data;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = head_data;
  assign bus.credit_ret = credit;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc_status
    assign bus.vc_nonempty[v]                 = (count[v] != '0);
    assign bus.almost_full[v]                 = (count[v] >= AFULL_CNT);
    assign bus.occupancy[v*CNT_W +: CNT_W]    = count[v];
  end

`ifdef VC_FIFO_ERR_EN
  logic [NUM_VC-1:0] err_ovf;
  logic [NUM_VC-1:0] err_unf;

  // Flags observe raw requests; the data path ignores them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_ovf <= '0;
      err_unf <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (bus.in_valid && (bus.in_vc == VC_W'(v)) && (count[v] == FULL_CNT))
          err_ovf[v] <= 1'b1;
        if (bus.out_ready && (bus.out_sel == VC_W'(v)) && (count[v] == '0))
          err_unf[v] <= 1'b1;
      end
    end
  end

  assign bus.err_overflow  = err_ovf;
  assign bus.err_underflow = err_unf;
`endif
endmodule

`default_nettype wire

// File: tb/tb_vc_fifo.sv
// Randomized bench for vc_fifo with a queue-per-VC reference model and
// a few hand-computed directed expectations.
`default_nettype none

module tb_vc_fifo;
  localparam int WIDTH  = 64;
  localparam int NUM_VC = 2;
  localparam int DEPTH  = 4;
  localparam int VC_W   = $clog2(NUM_VC);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  vc_fifo_if #(.WIDTH(WIDTH), .NUM_VC(NUM_VC), .DEPTH(DEPTH)) bus ();

  vc_fifo #(.WIDTH(WIDTH), .NUM_VC(NUM_VC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per VC, credits as last-cycle pops.
  logic [WIDTH-1:0]  q [NUM_VC][$];
  logic [NUM_VC-1:0] exp_credit = '0;
`ifdef VC_FIFO_ERR_EN
  logic [NUM_VC-1:0] exp_ovf = '0;
  logic [NUM_VC-1:0] exp_unf = '0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int  iv;
    int  os;
    bit  do_push;
    bit  do_pop;
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) q[v].delete();
      exp_credit = '0;
`ifdef VC_FIFO_ERR_EN
      exp_ovf = '0;
      exp_unf = '0;
`endif
    end else begin
      iv      = int'(bus.in_vc);
      os      = int'(bus.out_sel);
      do_push = bus.in_valid && (q[iv].size() < DEPTH);
      do_pop  = bus.out_ready && (q[os].size() != 0);
`ifdef VC_FIFO_ERR_EN
      if (bus.in_valid && q[iv].size() == DEPTH) exp_ovf[iv] = 1'b1;
      if (bus.out_ready && q[os].size() == 0)    exp_unf[os] = 1'b1;
`endif
      exp_credit = '0;
      if (do_pop) begin
        void'(q[os].pop_front());
        exp_credit[os] = 1'b1;
      end
      if (do_push) q[iv].push_back(bus.in_data);
    end
  end

  always @(negedge clk) begin : compare
    int iv;
    int os;
    if (chk_en) begin
      iv = int'(bus.in_vc);
      os = int'(bus.out_sel);
      chk("in_ready", 64'(bus.in_ready), 64'(q[iv].size() < DEPTH));
      chk("out_valid", 64'(bus.out_valid), 64'(q[os].size() != 0));
      if (q[os].size() != 0) chk("out_data", bus.out_data, q[os][0]);
      for (int v = 0; v < NUM_VC; v++) begin
        chk("occupancy", 64'(bus.occupancy[v*CNT_W +: CNT_W]), 64'(q[v].size()));
        chk("vc_nonempty", 64'(bus.vc_nonempty[v]), 64'(q[v].size() != 0));
        chk("almost_full", 64'(bus.almost_full[v]), 64'(q[v].size() >= DEPTH - 1));
      end
      chk("credit_ret", 64'(bus.credit_ret), 64'(exp_credit));
`ifdef VC_FIFO_ERR_EN
      chk("err_overflow", 64'(bus.err_overflow), 64'(exp_ovf));
      chk("err_underflow", 64'(bus.err_underflow), 64'(exp_unf));
`endif
    end
  end

  task automatic drive(input bit iv, input int vc, input logic [63:0] d,
                       input int os, input bit ordy);
    bus.in_valid  = iv;
    bus.in_vc     = VC_W'(vc);
    bus.in_data   = d;
    bus.out_sel   = VC_W'(os);
    bus.out_ready = ordy;
  endtask

  task automatic idle();
    drive(1'b0, 0, 64'd0, 0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [WIDTH-1:0] pat [4];
    int ph;
    int push_pct;
    int pop_pct;

    idle();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    #2;
    chk("lit_reset_occ", 64'(bus.occupancy), 64'd0);
    chk("lit_reset_ready", 64'(bus.in_ready), 64'd1);
    chk("lit_reset_valid", 64'(bus.out_valid), 64'd0);
    tick();

    // Fill VC0 with A0..A3.
    for (int i = 0; i < 4; i++) begin
      pat[i] = 64'hA0A0_0000_0000_0000 | 64'(i);
      drive(1'b1, 0, pat[i], 0, 1'b0);
      tick();
    end
    idle();
    #2;
    chk("lit_full_ready_vc0", 64'(bus.in_ready), 64'd0);
    chk("lit_full_afull", 64'(bus.almost_full), 64'b01);
    chk("lit_full_occ", 64'(bus.occupancy), 64'o04);
    bus.in_vc = 1'b1;
    #1;
    chk("lit_ready_vc1", 64'(bus.in_ready), 64'd1);
    tick();

    // Drain in order; each credit lands one cycle after its pop.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 0, 64'd0, 0, 1'b1);
      #2;
      chk("lit_pop_data", bus.out_data, pat[i]);
      chk("lit_pop_credit", 64'(bus.credit_ret), (i > 0) ? 64'b01 : 64'b00);
      tick();
    end
    idle();
    #2;
    chk("lit_last_credit", 64'(bus.credit_ret), 64'b01);
    tick();
    #2;
    chk("lit_credit_cleared", 64'(bus.credit_ret), 64'b00);
    tick();

    // Full VC refuses a same-cycle push+pop; then push+pop at count 2.
    for (int i = 0; i < 4; i++) begin
      pat[i] = 64'hB0B0_0000_0000_0000 | 64'(i);
      drive(1'b1, 0, pat[i], 0, 1'b0);
      tick();
    end
    drive(1'b1, 0, 64'hDEAD_BEEF, 0, 1'b1);
    #2;
    chk("lit_fullpp_ready", 64'(bus.in_ready), 64'd0);
    chk("lit_fullpp_head", bus.out_data, pat[0]);
    tick();
    idle();
    #2;
    chk("lit_fullpp_occ", 64'(bus.occupancy[CNT_W-1:0]), 64'd3);
    chk("lit_fullpp_next", bus.out_data, pat[1]);
    drive(1'b0, 0, 64'd0, 0, 1'b1);
    tick();
    drive(1'b1, 0, 64'hC0C0_0000_0000_0000, 0, 1'b1);
    #2;
    chk("lit_pp2_head", bus.out_data, pat[2]);
    tick();
    idle();
    #2;
    chk("lit_pp2_occ", 64'(bus.occupancy[CNT_W-1:0]), 64'd2);
    chk("lit_pp2_order", bus.out_data, pat[3]);
    tick();

    // Reset with VC1 holding three flits, popping during the reset cycle.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1, 64'hD0D0_0000_0000_0000 | 64'(i), 1, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    drive(1'b0, 1, 64'd0, 1, 1'b1);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 0, 64'd0, 1, 1'b0);
    #2;
    chk("lit_rst_occ", 64'(bus.occupancy), 64'd0);
    chk("lit_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("lit_rst_credit", 64'(bus.credit_ret), 64'd0);
    tick();

`ifdef VC_FIFO_ERR_EN
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1, 64'(i), 0, 1'b0);
      tick();
    end
    drive(1'b1, 1, 64'hEE, 0, 1'b0);
    tick();
    idle();
    #2;
    chk("lit_err_ovf", 64'(bus.err_overflow), 64'b10);
    tick();
    #2;
    chk("lit_err_ovf_held", 64'(bus.err_overflow), 64'b10);
    drive(1'b0, 0, 64'd0, 0, 1'b1);
    tick();
    idle();
    #2;
    chk("lit_err_unf", 64'(bus.err_underflow), 64'b01);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif

    // Randomized traffic in push-heavy, pop-heavy and balanced phases.
    for (int i = 0; i < 3000; i++) begin
      ph       = (i / 150) % 3;
      push_pct = (ph == 0) ? 85 : (ph == 1) ? 25 : 55;
      pop_pct  = (ph == 0) ? 25 : (ph == 1) ? 85 : 55;
      rst_n    = ($urandom_range(0, 399) != 0);
      drive($urandom_range(0, 99) < push_pct, int'($urandom_range(0, NUM_VC - 1)),
            {$urandom, $urandom}, int'($urandom_range(0, NUM_VC - 1)),
            $urandom_range(0, 99) < pop_pct);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
